// File: rtl/ssp_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssp_pkg : shared defaults and width helpers for the SSP RX FIFO    |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
package ssp_pkg;
  localparam int SSP_DATA_W   = 16;
  localparam int SSP_DEPTH    = 8;
  localparam int SSP_TO_TICKS = 32;
  // Timeout counter is sized for the largest legal TO_TICKS (255).
  localparam int SSP_TO_W     = 8;

  // Occupancy needs one more bit than a pointer so that DEPTH itself fits.
  function automatic int ssp_lvl_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/ssp_rx_fifo_mem.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssp_rx_fifo_mem : DATA_W x DEPTH register file, 1 write / 1 read   |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module ssp_rx_fifo_mem
  import ssp_pkg::*;
#(
  parameter int DATA_W = SSP_DATA_W,
  parameter int DEPTH  = SSP_DEPTH,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              WrEn,
  input  logic [PTR_W-1:0]  WrPtr,
  input  logic [DATA_W-1:0] WrData,
  input  logic [PTR_W-1:0]  RdPtr,
  output logic [DATA_W-1:0] RdData
);

  logic [DATA_W-1:0] r_mem [DEPTH];

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (WrEn) begin
      r_mem[WrPtr] <= WrData;
    end
  end

  assign RdData = r_mem[RdPtr];

endmodule
`default_nettype wire

// File: rtl/ssp_rx_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | ssp_rx_fifo_param : parametrised SSP receive FIFO with watermark,  |
// | occupancy, flush and receive-timeout interrupt. Rev 1.0            |
// +--------------------------------------------------------------------+
module ssp_rx_fifo_param
  import ssp_pkg::*;
#(
  parameter int DATA_W   = SSP_DATA_W,
  parameter int DEPTH    = SSP_DEPTH,
  parameter int PTR_W    = $clog2(DEPTH),
  parameter int TO_TICKS = SSP_TO_TICKS
) (
  input  logic              PCLK,
  input  logic              PRESETn,
  input  logic              MS,
  input  logic [DATA_W-1:0] SRxFWrData,
  input  logic [DATA_W-1:0] MRxFWrData,
  input  logic              RxFWrSync,
  input  logic              RxFRdPtrInc,
  input  logic              TESTFIFO,
  input  logic [DATA_W-1:0] PWDATAIn,
  input  logic              SSPTDRWr,
  input  logic [PTR_W:0]    RxWatermark,
  input  logic              RxToTick,
  input  logic              FLUSH,
  input  logic              RXIM,
  input  logic              RORIM,
  input  logic              RTIM,
  input  logic              RORIC,
  input  logic              RTIC,
  output logic              RNE,
  output logic              RFF,
  output logic [PTR_W:0]    RxLevel,
  output logic [DATA_W-1:0] RxFRdData,
  output logic              RXRIS,
  output logic              RORRIS,
  output logic              RTRIS,
  output logic              RXMIS,
  output logic              RORMIS,
  output logic              RTMIS
);

  localparam int                  c_lvl_w  = ssp_lvl_w(DEPTH);
  localparam logic [c_lvl_w-1:0]  c_full   = c_lvl_w'(DEPTH);
  localparam logic [SSP_TO_W-1:0] c_to_max = SSP_TO_W'(TO_TICKS);

  logic [PTR_W-1:0]    r_wr_ptr, r_rd_ptr;
  logic [c_lvl_w-1:0]  r_level;
  logic [SSP_TO_W-1:0] r_to_cnt;
  logic                r_ror, r_rt;

  logic                w_wr_req, w_rd_acc, w_wr_acc, w_overrun;
  logic                w_empty, w_full, w_to_hit;
  logic [DATA_W-1:0]   w_wr_data, w_head;
  logic [c_lvl_w-1:0]  w_eff_wm;

  assign w_wr_req  = TESTFIFO ? SSPTDRWr : RxFWrSync;
  assign w_wr_data = TESTFIFO ? PWDATAIn : (MS ? SRxFWrData : MRxFWrData);

  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == c_full);
  assign w_rd_acc  = RxFRdPtrInc && !w_empty && !FLUSH;
  // A full FIFO still takes a write when the same cycle frees a slot.
  assign w_wr_acc  = w_wr_req && (!w_full || w_rd_acc) && !FLUSH;
  assign w_overrun = w_wr_req && w_full && !w_rd_acc && !FLUSH;
  assign w_to_hit  = RxToTick && (r_to_cnt + 1'b1 == c_to_max);

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (FLUSH) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_wr_acc && !w_rd_acc)      r_level <= r_level + 1'b1;
      else if (w_rd_acc && !w_wr_acc) r_level <= r_level - 1'b1;
    end
  end

  // Inactivity timer: restarts on any FIFO traffic, idles while empty.
  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      r_to_cnt <= '0;
      r_rt     <= 1'b0;
    end else if (FLUSH) begin
      r_to_cnt <= '0;
      r_rt     <= 1'b0;
    end else begin
      if (w_empty || w_rd_acc || w_wr_acc) begin
        r_to_cnt <= '0;
      end else if (RxToTick && r_to_cnt != c_to_max) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (!w_empty && !w_wr_acc && r_to_cnt != c_to_max && w_to_hit) r_rt <= 1'b1;
      else if (RTIC || w_rd_acc)                                    r_rt <= 1'b0;
    end
  end

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn)       r_ror <= 1'b0;
    else if (w_overrun) r_ror <= 1'b1;
    else if (RORIC)     r_ror <= 1'b0;
  end

  ssp_rx_fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .PTR_W  (PTR_W)
  ) u_mem (
    .PCLK    (PCLK),
    .PRESETn (PRESETn),
    .WrEn    (w_wr_acc),
    .WrPtr   (r_wr_ptr),
    .WrData  (w_wr_data),
    .RdPtr   (r_rd_ptr),
    .RdData  (w_head)
  );

  always_comb begin
    w_eff_wm = RxWatermark;
    if (RxWatermark == '0)         w_eff_wm = c_lvl_w'(1);
    else if (RxWatermark > c_full) w_eff_wm = c_full;
  end

  assign RNE       = !w_empty;
  assign RFF       = w_full;
  assign RxLevel   = r_level;
  assign RxFRdData = w_empty ? '0 : w_head;
  assign RXRIS     = (r_level >= w_eff_wm);
  assign RORRIS    = r_ror;
  assign RTRIS     = r_rt;
  assign RXMIS     = RXRIS && RXIM;
  assign RORMIS    = r_ror && RORIM;
  assign RTMIS     = r_rt && RTIM;

endmodule
`default_nettype wire

// File: tb/tb_ssp_rx_fifo_param.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_ssp_rx_fifo_param : scoreboard bench for ssp_rx_fifo_param      |
// | Rev 1.0                                                            |
// +--------------------------------------------------------------------+
module tb_ssp_rx_fifo_param;
  localparam int DATA_W = 16, DEPTH = 8, PTR_W = 3, TO_TICKS = 32;

  logic              PCLK = 1'b0, PRESETn = 1'b0;
  logic              MS = 1'b0, RxFWrSync = 1'b0, RxFRdPtrInc = 1'b0;
  logic              TESTFIFO = 1'b0, SSPTDRWr = 1'b0, RxToTick = 1'b0, FLUSH = 1'b0;
  logic              RXIM = 1'b0, RORIM = 1'b0, RTIM = 1'b0, RORIC = 1'b0, RTIC = 1'b0;
  logic [DATA_W-1:0] SRxFWrData = '0, MRxFWrData = '0, PWDATAIn = '0;
  logic [PTR_W:0]    RxWatermark = 4'd1;
  logic              RNE, RFF, RXRIS, RORRIS, RTRIS, RXMIS, RORMIS, RTMIS;
  logic [PTR_W:0]    RxLevel;
  logic [DATA_W-1:0] RxFRdData;

  int n_tests = 0, n_fail = 0;
  logic [DATA_W-1:0] sb[$];

  ssp_rx_fifo_param #(.DATA_W(DATA_W), .DEPTH(DEPTH), .TO_TICKS(TO_TICKS)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn), .MS(MS), .SRxFWrData(SRxFWrData),
    .MRxFWrData(MRxFWrData), .RxFWrSync(RxFWrSync), .RxFRdPtrInc(RxFRdPtrInc),
    .TESTFIFO(TESTFIFO), .PWDATAIn(PWDATAIn), .SSPTDRWr(SSPTDRWr),
    .RxWatermark(RxWatermark), .RxToTick(RxToTick), .FLUSH(FLUSH),
    .RXIM(RXIM), .RORIM(RORIM), .RTIM(RTIM), .RORIC(RORIC), .RTIC(RTIC),
    .RNE(RNE), .RFF(RFF), .RxLevel(RxLevel), .RxFRdData(RxFRdData),
    .RXRIS(RXRIS), .RORRIS(RORRIS), .RTRIS(RTRIS),
    .RXMIS(RXMIS), .RORMIS(RORMIS), .RTMIS(RTMIS)
  );

  always #5 PCLK = ~PCLK;

  task automatic tick();
    @(posedge PCLK); #1;
  endtask

  // Normal-mode single-frame write; the model keeps what a FIFO would keep.
  task automatic push_word(input logic [DATA_W-1:0] d);
    if (MS) SRxFWrData = d; else MRxFWrData = d;
    RxFWrSync = 1'b1; tick(); RxFWrSync = 1'b0;
    if (sb.size() < DEPTH) sb.push_back(d);
  endtask

  task automatic pop_word();
    RxFRdPtrInc = 1'b1; tick(); RxFRdPtrInc = 1'b0;
    if (sb.size() > 0) sb.delete(0);
  endtask

  task automatic ticks(input int n);
    RxToTick = 1'b1;
    repeat (n) tick();
    RxToTick = 1'b0;
  endtask

  task automatic test_reset();
    n_tests++;
    if ({RNE, RFF, RXRIS, RORRIS, RTRIS, RXMIS, RORMIS, RTMIS} !== 8'h00) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 00000000",
                         {RNE, RFF, RXRIS, RORRIS, RTRIS, RXMIS, RORMIS, RTMIS});
    end
    n_tests++;
    if (RxLevel !== 4'd0 || RxFRdData !== 16'h0) begin
      n_fail++; $display("FAIL reset_level_data: got %0d/%h expected 0/0000", RxLevel, RxFRdData);
    end
  endtask

  task automatic test_fill_drain();
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    n_tests++;
    if (RFF !== 1'b1 || RxLevel !== 4'd8) begin
      n_fail++; $display("FAIL fill_full: got RFF=%b level=%0d expected 1/8", RFF, RxLevel);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (RxFRdData !== sb[0]) begin
        n_fail++; $display("FAIL drain_data[%0d]: got %h expected %h", i, RxFRdData, sb[0]);
      end
      pop_word();
    end
    n_tests++;
    if (RNE !== 1'b0 || RxFRdData !== 16'h0) begin
      n_fail++; $display("FAIL drain_empty: got RNE=%b data=%h expected 0/0000", RNE, RxFRdData);
    end
  endtask

  task automatic test_overrun();
    RORIM = 1'b1;
    for (int i = 1; i <= 8; i++) push_word(16'(i));
    push_word(16'hBEEF);
    n_tests++;
    if (RORRIS !== 1'b1 || RORMIS !== 1'b1 || RxLevel !== 4'd8 || RxFRdData !== sb[0]) begin
      n_fail++; $display("FAIL overrun_set: got ror=%b mis=%b lvl=%0d head=%h expected 1/1/8/%h",
                         RORRIS, RORMIS, RxLevel, RxFRdData, sb[0]);
    end
    RORIC = 1'b1; tick(); RORIC = 1'b0;
    n_tests++;
    if (RORRIS !== 1'b0) begin
      n_fail++; $display("FAIL overrun_clear: got %b expected 0", RORRIS);
    end
    MRxFWrData = 16'h0009; RxFWrSync = 1'b1; RxFRdPtrInc = 1'b1; tick();
    RxFWrSync = 1'b0; RxFRdPtrInc = 1'b0;
    sb.delete(0); sb.push_back(16'h0009);
    n_tests++;
    if (RORRIS !== 1'b0 || RxLevel !== 4'd8 || RxFRdData !== sb[0]) begin
      n_fail++; $display("FAIL full_wr_rd: got ror=%b lvl=%0d head=%h expected 0/8/%h",
                         RORRIS, RxLevel, RxFRdData, sb[0]);
    end
    MRxFWrData = 16'hCAFE; RxFWrSync = 1'b1; RORIC = 1'b1; tick();
    RxFWrSync = 1'b0; RORIC = 1'b0;
    n_tests++;
    if (RORRIS !== 1'b1) begin
      n_fail++; $display("FAIL overrun_set_wins: got %b expected 1", RORRIS);
    end
    for (int i = 0; i < 8; i++) begin
      n_tests++;
      if (RxFRdData !== sb[0]) begin
        n_fail++; $display("FAIL overrun_contents[%0d]: got %h expected %h", i, RxFRdData, sb[0]);
      end
      pop_word();
    end
  endtask

  task automatic test_watermark();
    RxWatermark = 4'd3; RXIM = 1'b1;
    push_word(16'h0A01); push_word(16'h0A02);
    n_tests++;
    if (RXMIS !== 1'b0) begin
      n_fail++; $display("FAIL wm_below: got %b expected 0", RXMIS);
    end
    push_word(16'h0A03);
    n_tests++;
    if (RXMIS !== 1'b1) begin
      n_fail++; $display("FAIL wm_reach: got %b expected 1", RXMIS);
    end
    pop_word();
    n_tests++;
    if (RXMIS !== 1'b0 || RxLevel !== 4'd2) begin
      n_fail++; $display("FAIL wm_fall: got mis=%b lvl=%0d expected 0/2", RXMIS, RxLevel);
    end
    pop_word();
    RxWatermark = 4'd0; #1;
    n_tests++;
    if (RXRIS !== 1'b1) begin
      n_fail++; $display("FAIL wm_zero: got %b expected 1", RXRIS);
    end
    RxWatermark = 4'd15; #1;
    n_tests++;
    if (RXRIS !== 1'b0) begin
      n_fail++; $display("FAIL wm_clamp: got %b expected 0", RXRIS);
    end
    n_tests++;
    if (RxFRdData !== sb[0]) begin
      n_fail++; $display("FAIL wm_data: got %h expected %h", RxFRdData, sb[0]);
    end
    pop_word();
    RxWatermark = 4'd1; RXIM = 1'b0;
  endtask

  task automatic test_timeout();
    RTIM = 1'b1;
    push_word(16'h7001);
    ticks(TO_TICKS - 1);
    n_tests++;
    if (RTRIS !== 1'b0) begin
      n_fail++; $display("FAIL to_early: got %b expected 0", RTRIS);
    end
    ticks(1);
    n_tests++;
    if (RTRIS !== 1'b1 || RTMIS !== 1'b1) begin
      n_fail++; $display("FAIL to_fire: got ris=%b mis=%b expected 1/1", RTRIS, RTMIS);
    end
    pop_word();
    n_tests++;
    if (RTRIS !== 1'b0) begin
      n_fail++; $display("FAIL to_pop_clear: got %b expected 0", RTRIS);
    end
    push_word(16'h7002);
    ticks(20);
    RxToTick = 1'b1;
    push_word(16'h7003);
    ticks(TO_TICKS - 1);
    n_tests++;
    if (RTRIS !== 1'b0) begin
      n_fail++; $display("FAIL to_restart: got %b expected 0", RTRIS);
    end
    ticks(1);
    n_tests++;
    if (RTRIS !== 1'b1) begin
      n_fail++; $display("FAIL to_refire: got %b expected 1", RTRIS);
    end
    RTIC = 1'b1; tick(); RTIC = 1'b0;
    n_tests++;
    if (RTRIS !== 1'b0) begin
      n_fail++; $display("FAIL to_rtic: got %b expected 0", RTRIS);
    end
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (RxFRdData !== sb[0]) begin
        n_fail++; $display("FAIL to_data[%0d]: got %h expected %h", i, RxFRdData, sb[0]);
      end
      pop_word();
    end
    RTIM = 1'b0;
  endtask

  task automatic test_testmode();
    TESTFIFO = 1'b1;
    MRxFWrData = 16'h5555; RxFWrSync = 1'b1; tick(); RxFWrSync = 1'b0;
    n_tests++;
    if (RNE !== 1'b0) begin
      n_fail++; $display("FAIL tm_ignore_sync: got RNE=%b expected 0", RNE);
    end
    PWDATAIn = 16'h1234; SSPTDRWr = 1'b1; tick(); SSPTDRWr = 1'b0;
    sb.push_back(16'h1234);
    n_tests++;
    if (RxFRdData !== 16'h1234 || RxLevel !== 4'd1) begin
      n_fail++; $display("FAIL tm_write: got %h/%0d expected 1234/1", RxFRdData, RxLevel);
    end
    TESTFIFO = 1'b0; MS = 1'b1; MRxFWrData = 16'hDEAD;
    push_word(16'hABCD);
    for (int i = 0; i < 2; i++) begin
      n_tests++;
      if (RxFRdData !== sb[0]) begin
        n_fail++; $display("FAIL src_mux[%0d]: got %h expected %h", i, RxFRdData, sb[0]);
      end
      pop_word();
    end
    MS = 1'b0;
  endtask

  task automatic test_flush();
    for (int i = 0; i < 5; i++) push_word(16'h3300 + 16'(i));
    MRxFWrData = 16'h7777; RxFWrSync = 1'b1; FLUSH = 1'b1; tick();
    RxFWrSync = 1'b0; FLUSH = 1'b0;
    sb.delete();
    n_tests++;
    if (RxLevel !== 4'd0 || RNE !== 1'b0 || RxFRdData !== 16'h0 || RORRIS !== 1'b1) begin
      n_fail++; $display("FAIL flush: got lvl=%0d rne=%b data=%h ror=%b expected 0/0/0000/1",
                         RxLevel, RNE, RxFRdData, RORRIS);
    end
    push_word(16'h4242);
    n_tests++;
    if (RxFRdData !== sb[0] || RxLevel !== 4'd1) begin
      n_fail++; $display("FAIL flush_refill: got %h/%0d expected %h/1", RxFRdData, RxLevel, sb[0]);
    end
  endtask

  task automatic test_async_reset();
    push_word(16'h0101); push_word(16'h0202);
    MRxFWrData = 16'h0303; RxFWrSync = 1'b1; RxToTick = 1'b1;
    #2 PRESETn = 1'b0;
    #1;
    n_tests++;
    if ({RNE, RFF, RXRIS, RORRIS, RTRIS, RXMIS, RORMIS, RTMIS} !== 8'h00 ||
        RxLevel !== 4'd0 || RxFRdData !== 16'h0) begin
      n_fail++; $display("FAIL async_reset: got flags=%b lvl=%0d data=%h expected 0/0/0000",
                         {RNE, RFF, RXRIS, RORRIS, RTRIS, RXMIS, RORMIS, RTMIS}, RxLevel, RxFRdData);
    end
    tick();
    RxFWrSync = 1'b0; RxToTick = 1'b0; PRESETn = 1'b1;
    sb.delete();
    tick();
    n_tests++;
    if (RxLevel !== 4'd0 || RNE !== 1'b0) begin
      n_fail++; $display("FAIL post_reset: got lvl=%0d rne=%b expected 0/0", RxLevel, RNE);
    end
  endtask

  task automatic test_wrap();
    logic [DATA_W-1:0] d;
    push_word(16'h9000);
    for (int i = 0; i < 20; i++) begin
      d = 16'h9001 + 16'(i * 16'h0111);
      n_tests++;
      if (RxFRdData !== sb[0]) begin
        n_fail++; $display("FAIL wrap_data[%0d]: got %h expected %h", i, RxFRdData, sb[0]);
      end
      MRxFWrData = d; RxFWrSync = 1'b1; RxFRdPtrInc = 1'b1; tick();
      RxFWrSync = 1'b0; RxFRdPtrInc = 1'b0;
      sb.delete(0); sb.push_back(d);
    end
    n_tests++;
    if (RxLevel !== 4'd1 || RxFRdData !== sb[0]) begin
      n_fail++; $display("FAIL wrap_end: got %0d/%h expected 1/%h", RxLevel, RxFRdData, sb[0]);
    end
    pop_word();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    repeat (2) @(posedge PCLK);
    #1;
    test_reset();
    PRESETn = 1'b1;
    tick();
    test_fill_drain();
    test_overrun();
    test_watermark();
    test_timeout();
    test_testmode();
    test_flush();
    test_async_reset();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
